// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single asynchronous 16-bit SRAM.
// A VGA read port gets one word per clock. A write port is serviced by a
// three-cycle setup/pulse/hold sequence. A starvation counter bounds how
// many consecutive reads a pending write can lose before it is forced in.
module sram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   // Frame-buffer read port
   input  logic        vga_req,
   input  logic [19:0] vga_addr,
   output logic [15:0] vga_data,
   output logic        vga_valid,
   output logic        vga_stall,
   // Write port
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ack,
   // SRAM pins
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StRead    = 3'd1;
   localparam logic [2:0] StWrSetup = 3'd2;
   localparam logic [2:0] StWrPulse = 3'd3;
   localparam logic [2:0] StWrHold  = 3'd4;

   localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

   logic [2:0]  state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [19:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q;
   logic        valid_q;
   logic        rd_grant;
   logic        dq_oe;

   // Grant decision and next-state logic; only IDLE and READ may grant.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_grant = 1'b0;
      // A withdrawn write request forgets any accumulated starvation.
      starve_d = wr_req ? starve_q : 4'd0;
      case (state_q)
         StIdle, StRead: begin
            if (wr_req && (starve_q == LimitCnt)) begin
               state_d  = StWrSetup;
               addr_d   = wr_addr;
               wdata_d  = wr_data;
               starve_d = 4'd0;
            end else if (vga_req) begin
               state_d  = StRead;
               addr_d   = vga_addr;
               rd_grant = 1'b1;
               if (wr_req && (starve_q < LimitCnt)) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (wr_req) begin
               state_d  = StWrSetup;
               addr_d   = wr_addr;
               wdata_d  = wr_data;
               starve_d = 4'd0;
            end else begin
               state_d = StIdle;
            end
         end
         StWrSetup: state_d = StWrPulse;
         StWrPulse: state_d = StWrHold;
         // Always return through IDLE so the bus turns around before a read.
         StWrHold:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State, latched transaction and starvation counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= StIdle;
         starve_q <= 4'd0;
         addr_q   <= 20'd0;
         wdata_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Capture read data at the end of each READ cycle; valid follows one cycle later.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rdata_q <= 16'd0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_q == StRead);
         if (state_q == StRead) begin
            rdata_q <= SRAM_DQ;
         end
      end
   end

   assign dq_oe = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);

   assign SRAM_DQ   = dq_oe ? wdata_q : 16'hzzzz;
   assign SRAM_ADDR = addr_q;
   assign SRAM_OE_N = (state_q != StRead);
   assign SRAM_WE_N = (state_q != StWrPulse);
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   assign vga_data  = rdata_q;
   assign vga_valid = valid_q;
   assign vga_stall = vga_req && !rd_grant;
   assign wr_ack    = (state_q == StWrHold);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with an asynchronous SRAM model on the bus.
module tb_sram_arbiter;

   localparam int unsigned Limit = 8;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        vga_req;
   logic [19:0] vga_addr;
   logic [15:0] vga_data;
   logic        vga_valid;
   logic        vga_stall;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] sram_dq;
   logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;

   int checks = 0;
   int errors = 0;

   // SRAM model storage, plus a preload path and a probe driver that parks 0 on the bus.
   logic [15:0] mem [0:1048575];
   logic        pl_en = 1'b0;
   logic [19:0] pl_addr = 20'd0;
   logic [15:0] pl_data = 16'd0;
   logic        probe = 1'b0;

   // Reference copy of the 16-word region at 0x100 used by reads and random traffic.
   logic [15:0] exp_mem [0:15];

   sram_arbiter #(.STARVE_LIMIT(Limit)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .vga_req   (vga_req),
      .vga_addr  (vga_addr),
      .vga_data  (vga_data),
      .vga_valid (vga_valid),
      .vga_stall (vga_stall),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (sram_dq),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_WE_N (SRAM_WE_N)
   );

   always #5 Clk = ~Clk;

   assign sram_dq = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
   assign sram_dq = probe ? 16'h0000 : 16'hzzzz;

   // Memory array update: preload, or commit while WE_N is low.
   always @(posedge Clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!SRAM_WE_N) mem[SRAM_ADDR] <= sram_dq;
   end

   // Bus protocol: OE_N and WE_N are never low together.
   always @(negedge Clk) begin
      if (Reset !== 1'b1) begin
         assert (!(SRAM_OE_N === 1'b0 && SRAM_WE_N === 1'b0))
            else $error("FAIL oe_we_overlap: OE_N=%b WE_N=%b", SRAM_OE_N, SRAM_WE_N);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic preload(input logic [19:0] a, input logic [15:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge Clk);
      pl_en   = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vga_valid); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", SRAM_OE_N); end
      checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we: got %b want 1", SRAM_WE_N); end
      checks++; if (SRAM_ADDR !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
      checks++; if (vga_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", vga_data); end
      checks++; if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000) begin
         errors++; $display("FAIL reset_ce_ub_lb: got %b want 000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N});
      end
      probe = 1'b1;
      #1;
      checks++; if (sram_dq !== 16'h0000) begin errors++; $display("FAIL reset_dq_hiz: got %h want 0000", sram_dq); end
      probe = 1'b0;
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      vga_addr = 20'h00010;
      vga_req  = 1'b1;
      #1;
      checks++; if (vga_stall !== 1'b0) begin errors++; $display("FAIL read_stall: got %b want 0", vga_stall); end
      tick();
      vga_req = 1'b0;
      checks++; if (SRAM_OE_N !== 1'b0) begin errors++; $display("FAIL read_oe: got %b want 0", SRAM_OE_N); end
      checks++; if (SRAM_ADDR !== 20'h00010) begin errors++; $display("FAIL read_addr: got %h want 00010", SRAM_ADDR); end
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %b want 0", vga_valid); end
      tick();
      checks++; if (vga_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b want 1", vga_valid); end
      checks++; if (vga_data !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h want BEEF", vga_data); end
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL read_oe_one_cycle: got %b want 1", SRAM_OE_N); end
      tick();
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL read_valid_pulse: got %b want 0", vga_valid); end
   endtask

   task automatic test_single_write();
      wr_addr = 20'h12345;
      wr_data = 16'h00A5;
      wr_req  = 1'b1;
      tick();
      checks++; if ({SRAM_OE_N, SRAM_WE_N} !== 2'b11) begin errors++; $display("FAIL wr_setup_ctl: got %b want 11", {SRAM_OE_N, SRAM_WE_N}); end
      checks++; if (SRAM_ADDR !== 20'h12345) begin errors++; $display("FAIL wr_setup_addr: got %h want 12345", SRAM_ADDR); end
      checks++; if (sram_dq !== 16'h00A5) begin errors++; $display("FAIL wr_setup_dq: got %h want 00A5", sram_dq); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_setup_ack: got %b want 0", wr_ack); end
      tick();
      checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL wr_pulse_we: got %b want 0", SRAM_WE_N); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_pulse_ack: got %b want 0", wr_ack); end
      tick();
      checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL wr_hold_we: got %b want 1", SRAM_WE_N); end
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_hold_ack: got %b want 1", wr_ack); end
      checks++; if (sram_dq !== 16'h00A5) begin errors++; $display("FAIL wr_hold_dq: got %h want 00A5", sram_dq); end
      wr_req = 1'b0;
      tick();
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_idle_ack: got %b want 0", wr_ack); end
      checks++; if ({SRAM_OE_N, SRAM_WE_N} !== 2'b11) begin errors++; $display("FAIL wr_idle_ctl: got %b want 11", {SRAM_OE_N, SRAM_WE_N}); end
      checks++; if (mem[20'h12345] !== 16'h00A5) begin errors++; $display("FAIL wr_mem: got %h want 00A5", mem[20'h12345]); end
   endtask

   task automatic test_starvation();
      int  n_reads = 0;
      bit  done = 1'b0;
      vga_req = 1'b1;
      wr_req  = 1'b1;
      wr_addr = 20'h00030;
      wr_data = 16'h5A5A;
      for (int i = 0; i < 20 && !done; i++) begin
         vga_addr = 20'h00100 + 20'(i);
         tick();
         if (SRAM_OE_N === 1'b0) n_reads++;
         else done = 1'b1;
      end
      checks++; if (n_reads != Limit) begin errors++; $display("FAIL starve_reads: got %0d want %0d", n_reads, Limit); end
      checks++; if (vga_valid !== 1'b1 || vga_data !== exp_mem[7]) begin
         errors++; $display("FAIL starve_last_read: valid %b data %h want 1 %h", vga_valid, vga_data, exp_mem[7]);
      end
      checks++; if (sram_dq !== 16'h5A5A) begin errors++; $display("FAIL starve_setup_dq: got %h want 5A5A", sram_dq); end
      checks++; if (vga_stall !== 1'b1) begin errors++; $display("FAIL starve_stall_setup: got %b want 1", vga_stall); end
      tick();
      checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL starve_pulse_we: got %b want 0", SRAM_WE_N); end
      checks++; if (vga_stall !== 1'b1) begin errors++; $display("FAIL starve_stall_pulse: got %b want 1", vga_stall); end
      tick();
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL starve_ack: got %b want 1", wr_ack); end
      checks++; if (vga_stall !== 1'b1) begin errors++; $display("FAIL starve_stall_hold: got %b want 1", vga_stall); end
      wr_req = 1'b0;
      tick();
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL starve_idle_oe: got %b want 1", SRAM_OE_N); end
      checks++; if (vga_stall !== 1'b0) begin errors++; $display("FAIL starve_idle_grant: got %b want 0", vga_stall); end
      tick();
      vga_req = 1'b0;
      checks++; if (SRAM_OE_N !== 1'b0 || SRAM_ADDR !== 20'h00108) begin
         errors++; $display("FAIL starve_resume: oe %b addr %h want 0 00108", SRAM_OE_N, SRAM_ADDR);
      end
      tick();
      checks++; if (vga_valid !== 1'b1 || vga_data !== exp_mem[8]) begin
         errors++; $display("FAIL starve_resume_data: valid %b data %h want 1 %h", vga_valid, vga_data, exp_mem[8]);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      vga_addr = 20'h00101;
      vga_req  = 1'b1;
      wr_addr  = 20'h00031;
      wr_data  = 16'h7777;
      wr_req   = 1'b1;
      #1;
      checks++; if (vga_stall !== 1'b0) begin errors++; $display("FAIL simul_read_wins: got stall %b want 0", vga_stall); end
      tick();
      vga_req = 1'b0;
      checks++; if (SRAM_OE_N !== 1'b0) begin errors++; $display("FAIL simul_read_oe: got %b want 0", SRAM_OE_N); end
      tick();
      checks++; if (sram_dq !== 16'h7777 || SRAM_OE_N !== 1'b1) begin
         errors++; $display("FAIL simul_write_next: dq %h oe %b want 7777 1", sram_dq, SRAM_OE_N);
      end
      checks++; if (vga_valid !== 1'b1 || vga_data !== exp_mem[1]) begin
         errors++; $display("FAIL simul_read_data: valid %b data %h want 1 %h", vga_valid, vga_data, exp_mem[1]);
      end
      tick();
      tick();
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL simul_ack: got %b want 1", wr_ack); end
      wr_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      wr_addr = 20'h00040;
      wr_data = 16'hA5A5;
      wr_req  = 1'b1;
      tick();
      tick();
      checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL rstw_in_pulse: got %b want 0", SRAM_WE_N); end
      Reset = 1'b1;
      tick();
      checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rstw_we: got %b want 1", SRAM_WE_N); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rstw_ack: got %b want 0", wr_ack); end
      probe = 1'b1;
      #1;
      checks++; if (sram_dq !== 16'h0000) begin errors++; $display("FAIL rstw_dq_hiz: got %h want 0000", sram_dq); end
      probe  = 1'b0;
      Reset  = 1'b0;
      wr_req = 1'b0;
      vga_addr = 20'h00102;
      vga_req  = 1'b1;
      #1;
      checks++; if (vga_stall !== 1'b0) begin errors++; $display("FAIL rstw_idle_grant: got %b want 0", vga_stall); end
      tick();
      vga_req = 1'b0;
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rstw_no_late_ack: got %b want 0", wr_ack); end
      tick();
      checks++; if (vga_valid !== 1'b1 || vga_data !== exp_mem[2]) begin
         errors++; $display("FAIL rstw_read_data: valid %b data %h want 1 %h", vga_valid, vga_data, exp_mem[2]);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      vga_addr = 20'h00103;
      vga_req  = 1'b1;
      tick();
      vga_req = 1'b0;
      checks++; if (SRAM_OE_N !== 1'b0) begin errors++; $display("FAIL rstr_in_read: got %b want 0", SRAM_OE_N); end
      Reset = 1'b1;
      tick();
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL rstr_valid: got %b want 0", vga_valid); end
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rstr_oe: got %b want 1", SRAM_OE_N); end
      Reset = 1'b0;
      tick();
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL rstr_valid_late: got %b want 0", vga_valid); end
   endtask

   task automatic test_read_after_write();
      wr_addr = 20'h00020;
      wr_data = 16'h1234;
      wr_req  = 1'b1;
      tick();
      tick();
      tick();
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL raw_ack: got %b want 1", wr_ack); end
      wr_req   = 1'b0;
      vga_addr = 20'h00020;
      vga_req  = 1'b1;
      #1;
      checks++; if (vga_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_hold: got %b want 1", vga_stall); end
      tick();
      checks++; if (vga_stall !== 1'b0) begin errors++; $display("FAIL raw_idle_grant: got %b want 0", vga_stall); end
      tick();
      vga_req = 1'b0;
      tick();
      checks++; if (vga_valid !== 1'b1 || vga_data !== 16'h1234) begin
         errors++; $display("FAIL raw_data: valid %b data %h want 1 1234", vga_valid, vga_data);
      end
      tick();
   endtask

   // Random traffic against a timing model: a read is granted whenever the arbiter
   // is free and not forced to a write; a write blocks decisions for four cycles.
   task automatic test_random();
      localparam int N = 400;
      int          next_dec = 0;
      int          starve   = 0;
      int          ack_t    = -1;
      int          w_idx    = 0;
      int          r_idx;
      int          val_t[$];
      logic [15:0] val_d[$];
      bit          exp_valid, exp_ack, rd;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      for (int t = 0; t < N; t++) begin
         exp_valid = (val_t.size() > 0) && (val_t[0] == t);
         exp_ack   = (ack_t == t);
         checks++; if (vga_valid !== exp_valid) begin
            errors++; $display("FAIL rand_valid t=%0d: got %b want %b", t, vga_valid, exp_valid);
         end
         if (exp_valid) begin
            checks++; if (vga_data !== val_d[0]) begin
               errors++; $display("FAIL rand_data t=%0d: got %h want %h", t, vga_data, val_d[0]);
            end
            void'(val_t.pop_front());
            void'(val_d.pop_front());
         end
         checks++; if (wr_ack !== exp_ack) begin
            errors++; $display("FAIL rand_ack t=%0d: got %b want %b", t, wr_ack, exp_ack);
         end
         if (exp_ack) wr_req = 1'b0;
         r_idx    = int'($urandom_range(0, 15));
         vga_addr = 20'h00100 + 20'(r_idx);
         vga_req  = (t < N - 10) && ($urandom_range(0, 2) != 0);
         if (!wr_req && !exp_ack && (t < N - 10) && ($urandom_range(0, 3) == 0)) begin
            w_idx   = int'($urandom_range(0, 15));
            wr_addr = 20'h00100 + 20'(w_idx);
            wr_data = 16'($urandom);
            wr_req  = 1'b1;
         end
         if (!wr_req) starve = 0;
         rd = 1'b0;
         if (t >= next_dec) begin
            if (wr_req && (starve == Limit || !vga_req)) begin
               exp_mem[w_idx] = wr_data;
               ack_t    = t + 3;
               next_dec = t + 4;
               starve   = 0;
            end else if (vga_req) begin
               rd = 1'b1;
               val_t.push_back(t + 2);
               val_d.push_back(exp_mem[r_idx]);
               if (wr_req && starve < Limit) starve++;
               next_dec = t + 1;
            end else begin
               next_dec = t + 1;
            end
         end
         #1;
         checks++; if (vga_stall !== (vga_req && !rd)) begin
            errors++; $display("FAIL rand_stall t=%0d: got %b want %b", t, vga_stall, vga_req && !rd);
         end
         tick();
      end
      checks++; if (val_t.size() != 0) begin
         errors++; $display("FAIL rand_drain: %0d reads outstanding want 0", val_t.size());
      end
   endtask

   initial begin
      Reset    = 1'b1;
      vga_req  = 1'b0;
      vga_addr = 20'h0;
      wr_req   = 1'b0;
      wr_addr  = 20'h0;
      wr_data  = 16'h0;
      @(negedge Clk);
      preload(20'h00010, 16'hBEEF);
      preload(20'h00020, 16'hDEAD);
      for (int i = 0; i < 16; i++) begin
         exp_mem[i] = 16'($urandom);
         preload(20'h00100 + 20'(i), exp_mem[i]);
      end
      test_reset();
      test_single_read();
      test_single_write();
      test_starvation();
      test_simultaneous();
      test_reset_mid_write();
      test_reset_mid_read();
      test_read_after_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
